// File: rtl/fb_scheduler.sv
// Double-buffered framebuffer port scheduler: scanout > clear > writer on one single-port RAM.
// Scan data returns one cycle after scan_req; writes are stalled (wr_ready=0) by scanout or a pending swap/clear.
module fb_scheduler #(
  parameter int          FB_W      = 320,
  parameter int          FB_H      = 240,
  parameter logic [2:0]  CLR_COLOR = 3'b000
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        new_frame,
  input  logic        scan_req,
  input  logic [8:0]  scan_x,
  input  logic [7:0]  scan_y,
  output logic [2:0]  scan_data,
  output logic        scan_valid,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic [8:0]  wr_x,
  input  logic [7:0]  wr_y,
  input  logic [2:0]  wr_color,
  input  logic        swap_req,
  input  logic        clear_on_swap,
  output logic        swap_done,
  output logic        busy,
  output logic        front_bank,
  output logic [17:0] mem_addr,
  output logic        mem_we,
  output logic [2:0]  mem_wdata,
  input  logic [2:0]  mem_rdata
);

  localparam int unsigned LP_PIX      = FB_W * FB_H;
  localparam logic [17:0] LP_BANK_OFS = 18'(LP_PIX);
  localparam logic [16:0] LP_LAST     = 17'(LP_PIX - 1);

  typedef enum logic [1:0] {RUN = 2'd0, WAIT_VB = 2'd1, CLEAR = 2'd2} state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_front;
  logic        r_nf_q;
  logic        r_clr_flag;
  logic        r_scan_vld;
  logic        r_swap_done;
  logic [16:0] r_clr_cnt;

  logic        w_nf_rise;
  logic        w_commit;
  logic        w_clr_wr;
  logic        w_clr_last;
  logic        w_busy;
  logic        w_wr_rdy;
  logic        w_wr_fire;
  logic        w_wr_inb;
  logic [17:0] w_front_base;
  logic [17:0] w_back_base;
  logic [17:0] w_scan_addr;
  logic [17:0] w_wr_addr;
  logic [17:0] w_clr_addr;
  logic [17:0] w_addr;
  logic        w_we;
  logic [2:0]  w_wdata;

  assign w_nf_rise  = new_frame & ~r_nf_q;
  assign w_clr_last = (r_clr_cnt == LP_LAST);

  always_ff @(posedge Clk) begin
    if (!Reset) r_state <= RUN;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      RUN:     if (swap_req)  w_state_nxt = WAIT_VB;
      WAIT_VB: if (w_nf_rise) w_state_nxt = r_clr_flag ? CLEAR : RUN;
      CLEAR:   if (w_clr_wr && w_clr_last) w_state_nxt = RUN;
      default: w_state_nxt = RUN;
    endcase
  end

  // Clear steps only in cycles the scanout leaves the RAM free.
  always_comb begin
    w_busy   = 1'b0;
    w_commit = 1'b0;
    w_clr_wr = 1'b0;
    case (r_state)
      WAIT_VB: begin
        w_busy   = 1'b1;
        w_commit = w_nf_rise;
      end
      CLEAR: begin
        w_busy   = 1'b1;
        w_clr_wr = ~scan_req;
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      r_front     <= 1'b0;
      r_nf_q      <= 1'b0;
      r_clr_flag  <= 1'b0;
      r_clr_cnt   <= '0;
      r_scan_vld  <= 1'b0;
      r_swap_done <= 1'b0;
    end else begin
      r_nf_q      <= new_frame;
      r_scan_vld  <= scan_req;
      r_swap_done <= w_commit;
      if (w_commit) r_front <= ~r_front;
      if (r_state == RUN && swap_req) r_clr_flag <= clear_on_swap;
      if (w_clr_wr) r_clr_cnt <= w_clr_last ? '0 : r_clr_cnt + 17'd1;
    end
  end

  assign w_front_base = r_front ? LP_BANK_OFS : 18'd0;
  assign w_back_base  = r_front ? 18'd0 : LP_BANK_OFS;
  assign w_scan_addr  = w_front_base + 18'(scan_y) * 18'(FB_W) + 18'(scan_x);
  assign w_wr_addr    = w_back_base + 18'(wr_y) * 18'(FB_W) + 18'(wr_x);
  assign w_clr_addr   = w_back_base + 18'(r_clr_cnt);

  assign w_wr_rdy  = (r_state == RUN) & Reset & ~scan_req;
  assign w_wr_fire = wr_valid & w_wr_rdy;
  assign w_wr_inb  = (32'(wr_x) < FB_W) && (32'(wr_y) < FB_H);

  always_comb begin
    w_addr  = w_wr_addr;
    w_we    = 1'b0;
    w_wdata = wr_color;
    if (scan_req) begin
      w_addr = w_scan_addr;
    end else if (w_clr_wr) begin
      w_addr  = w_clr_addr;
      w_we    = 1'b1;
      w_wdata = CLR_COLOR;
    end else if (w_wr_fire) begin
      w_we = w_wr_inb;
    end
  end

  assign mem_addr   = w_addr;
  assign mem_we     = w_we & Reset;
  assign mem_wdata  = w_wdata;
  assign wr_ready   = w_wr_rdy;
  assign scan_valid = r_scan_vld & Reset;
  assign scan_data  = scan_valid ? mem_rdata : 3'd0;
  assign swap_done  = r_swap_done & Reset;
  assign busy       = w_busy & Reset;
  assign front_bank = r_front & Reset;

endmodule

// File: doc/fb_scheduler.md
FB_SCHEDULER -- requirements
Module: fb_scheduler

Interface
REQ-001 Parameters SHALL be: FB_W, default 320, pixels per line; FB_H, default 240, lines per frame; CLR_COLOR, default 3'b000, palette index written by clear.
REQ-002 The ports SHALL be exactly as follows:
- Clk  in  1  sole clock; all logic rising-edge.
- Reset  in  1  synchronous, active-low reset (0 = reset).
- new_frame  in  1  vsync-derived frame pulse, high during vertical sync.
- scan_req  in  1  scanout read request this cycle.
- scan_x  in  9  scanout column.
- scan_y  in  8  scanout row.
- scan_data  out  3  palette index read for scanout.
- scan_valid  out  1  scan_data valid.
- wr_valid  in  1  draw-engine pixel write offered.
- wr_ready  out  1  write accepted this cycle.
- wr_x  in  9  write column.
- wr_y  in  8  write row.
- wr_color  in  3  write palette index.
- swap_req  in  1  one-cycle request to swap front/back banks.
- clear_on_swap  in  1  sampled with swap_req; clear the new back bank after the swap.
- swap_done  out  1  one-cycle pulse when the swap commits.
- busy  out  1  swap pending or clear running.
- front_bank  out  1  bank currently scanned out.
- mem_addr  out  18  single-port RAM address.
- mem_we  out  1  RAM write enable.
- mem_wdata  out  3  RAM write data.
- mem_rdata  in  3  RAM read data, 1-cycle synchronous read.

Function
REQ-003 Address arithmetic SHALL be bank*FB_W*FB_H + y*FB_W + x, computed as unsigned 18-bit with no truncation; y*320 SHALL equal (y<<8)+(y<<6).
REQ-004 Port priority each cycle SHALL be: scanout, then clear, then writer; exactly one of these sources drives mem_addr.
REQ-005 On scan_req=1, mem_addr SHALL address (front_bank, scan_x, scan_y) with mem_we=0; scan_valid SHALL be 1 and scan_data SHALL equal mem_rdata exactly one cycle later; otherwise scan_valid=0 and scan_data=0.
REQ-006 wr_ready SHALL be combinational: 1 iff state=RUN, Reset=1, scan_req=0; a write transfers when wr_valid and wr_ready are both 1.
REQ-007 A transferred write SHALL target bank !front_bank with mem_we=1 and mem_wdata=wr_color in the same cycle.
REQ-008 A transferred write with wr_x>=FB_W or wr_y>=FB_H SHALL be consumed and dropped, with mem_we=0.
REQ-009 The FSM SHALL have states RUN, WAIT_VB and CLEAR.
REQ-010 In RUN, swap_req=1 SHALL latch clear_on_swap and move to WAIT_VB.
REQ-011 In WAIT_VB, the first new_frame rising edge (registered 0->1) seen after entry SHALL toggle front_bank and pulse swap_done for one cycle; the next state SHALL be CLEAR if the latched flag is 1, else RUN.
REQ-012 A new_frame rising edge in the same cycle as swap_req SHALL NOT commit the swap; the swap SHALL wait for the next edge.
REQ-013 In CLEAR, a 17-bit counter SHALL write CLR_COLOR to every address of the new back bank, 0 to FB_W*FB_H-1, ascending.
REQ-014 The clear counter SHALL advance only in cycles with scan_req=0; after the write of the last address the FSM SHALL return to RUN.
REQ-015 swap_req SHALL be ignored in WAIT_VB and CLEAR.
REQ-016 busy SHALL be 1 iff state is WAIT_VB or CLEAR.
REQ-017 mem_we SHALL never be 1 in a cycle with scan_req=1.

Reset
REQ-018 While Reset=0: state=RUN, front_bank=0, scan_valid=0, scan_data=0, swap_done=0, busy=0, wr_ready=0, mem_we=0, clear counter=0, latched clear flag=0.
REQ-019 Reset asserted mid-WAIT_VB or mid-CLEAR SHALL abort the operation without committing a pending swap; bank contents are unspecified.

Verification
REQ-020 Scan read: scan_req=1, x=5, y=2, front_bank=0 -> mem_addr=645, mem_we=0; scan_valid=1 next cycle with scan_data=mem_rdata.
REQ-021 Write: wr_valid=1, x=319, y=239, color=6, scan_req=0 -> wr_ready=1, mem_we=1, mem_addr=76800+76799=153599, mem_wdata=6.
REQ-022 Conflict and bounds: wr_valid=1 with scan_req=1 -> wr_ready=0, mem_we=0, write held; wr_x=320 -> wr_ready=1, mem_we=0.
REQ-023 Swap without clear: swap_req=1, clear_on_swap=0 -> busy=1, wr_ready=0; at the next new_frame rising edge front_bank toggles to 1, swap_done pulses once, state returns to RUN.
REQ-024 Swap with clear under contention: swap with clear_on_swap=1 and scan_req at 50% duty -> exactly 76800 writes of CLR_COLOR to bank 0, no mem_we while scan_req=1, busy falls after the last write.
REQ-025 Reset=0 asserted at clear count 1000 -> next cycle state=RUN, front_bank=0, busy=0, mem_we=0.
